// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   XLEN_DEF  : default data width
//   DEPTH_DEF : default refill FIFO depth
//   REG_X0    : hard-wired zero register index
//   refill_t  : refill entry layout {rd, data} at the default width
package rf_wb_arbiter_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned RD_W      = 5;
  localparam int unsigned NREGS     = 32;

  localparam logic [RD_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [RD_W-1:0]     rd;
    logic [XLEN_DEF-1:0] data;
  } refill_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO buffering late load refills.
// Ports:
//   clk, RST       : clock, asynchronous active-low reset
//   push, wdata    : write request and entry (ignored when full without pop)
//   pop            : drop the head entry (ignored when empty)
//   rdata          : current head entry
//   full, empty    : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rf_wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned W     = RD_W + XLEN_DEF
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr == {~rptr[PW-1], rptr[AW-1:0]});
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  // Pointer update.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter and load-miss scoreboard.
// Ports:
//   clk, RST                    : clock, asynchronous active-low reset
//   wb_we/wb_rd/wb_data         : pipeline writeback (always wins the port)
//   miss_issue/miss_rd          : mark a destination pending on a cache miss
//   mem_valid/mem_rd/mem_data   : late refill data; mem_ready accepts it
//   dec_rs1/dec_rs2/dec_rd      : decode indices checked against busy
//   stall                       : decode must hold
//   WE3/A3/WD3                  : register file write port (combinational)
// Optional build macro: RF_WB_BYPASS_EN lets a refill skip an empty FIFO
// and write in its arrival cycle when the pipeline is not writing.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned XLEN  = XLEN_DEF
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            miss_issue,
  input  logic [4:0]      miss_rd,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  output logic            stall,
  output logic            WE3,
  output logic [4:0]      A3,
  output logic [XLEN-1:0] WD3
);

  localparam int unsigned EW = RD_W + XLEN;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_set;
  logic [NREGS-1:0] busy_clr;
  logic [EW-1:0]    head;
  logic [4:0]       head_rd;
  logic [XLEN-1:0]  head_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             wb_eff;
  logic             head_grant;
  logic             byp;
  logic             push;
  logic [4:0]       ref_rd;
  logic [XLEN-1:0]  ref_data;
  logic             ref_we;

  assign head_rd   = head[EW-1 -: RD_W];
  assign head_data = head[XLEN-1:0];

  // Writes to x0 are dropped and leave the port free for refills.
  assign wb_eff     = wb_we && (wb_rd != REG_X0);
  assign head_grant = !fifo_empty && !wb_eff;

`ifdef RF_WB_BYPASS_EN
  assign byp = RST && mem_valid && fifo_empty && !wb_eff;
`else
  assign byp = 1'b0;
`endif

  assign mem_ready = RST && (!fifo_full || head_grant);
  assign push      = mem_valid && mem_ready && !byp;

  // Refill source: bypassed arrival or FIFO head; rd=0 entries retire silently.
  assign ref_rd   = byp ? mem_rd   : head_rd;
  assign ref_data = byp ? mem_data : head_data;
  assign ref_we   = (byp || head_grant) && (ref_rd != REG_X0);

  // Write-port mux, held at zero while in reset.
  always_comb begin
    WE3 = 1'b0;
    A3  = '0;
    WD3 = '0;
    if (RST) begin
      if (wb_eff) begin
        WE3 = 1'b1;
        A3  = wb_rd;
        WD3 = wb_data;
      end else if (ref_we) begin
        WE3 = 1'b1;
        A3  = ref_rd;
        WD3 = ref_data;
      end
    end
  end

  rf_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .RST   (RST),
    .push  (push),
    .pop   (head_grant),
    .wdata ({mem_rd, mem_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Scoreboard masks; a same-cycle set overrides the clear.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (miss_issue && (miss_rd != REG_X0)) busy_set = NREGS'(1) << miss_rd;
    if (ref_we)                            busy_clr = NREGS'(1) << ref_rd;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) busy <= '0;
    else      busy <= ((busy & ~busy_clr) | busy_set) & ~NREGS'(1);
  end

  assign stall = RST && (busy[dec_rs1] || busy[dec_rs2] || busy[dec_rd]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (default build, FIFO path only).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        RST;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        miss_issue;
  logic [4:0]  miss_rd;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        stall;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk        (clk),
    .RST        (RST),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .miss_issue (miss_issue),
    .miss_rd    (miss_rd),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .dec_rd     (dec_rd),
    .stall      (stall),
    .WE3        (WE3),
    .A3         (A3),
    .WD3        (WD3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and move to the input-drive point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check_eq({tag, ".WE3"}, 32'(WE3), 32'(we));
    check_eq({tag, ".A3"},  32'(A3),  32'(a));
    check_eq({tag, ".WD3"}, WD3, d);
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    miss_issue = 1'b0; miss_rd = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
  endtask

  initial begin
    idle_inputs();
    RST = 1'b0;
    // Reset with an active pipeline write: everything must read zero.
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1111_2222;
    mem_valid = 1'b1; mem_rd = 5'd4;
    #1;
    check_port("rst", 1'b0, 5'd0, 32'h0);
    check_eq("rst.stall", 32'(stall), 32'd0);
    check_eq("rst.mem_ready", 32'(mem_ready), 32'd0);
    tick(); tick();
    idle_inputs();
    RST = 1'b1;
    #1;
    check_eq("rel.mem_ready", 32'(mem_ready), 32'd1);
    check_port("rel", 1'b0, 5'd0, 32'h0);

    // Miss to x5 then refill 0xDEADBEEF; one-cycle refill latency.
    tick();
    miss_issue = 1'b1; miss_rd = 5'd5; dec_rs1 = 5'd5;
    #1 check_eq("t1.stall_pre", 32'(stall), 32'd0);
    tick();
    miss_issue = 1'b0;
    #1 check_eq("t1.stall_set", 32'(stall), 32'd1);
    tick();
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hDEAD_BEEF;
    #1;
    check_eq("t1.ready", 32'(mem_ready), 32'd1);
    check_port("t1.acc", 1'b0, 5'd0, 32'h0);
    tick();
    mem_valid = 1'b0;
    #1;
    check_port("t1.wr", 1'b1, 5'd5, 32'hDEAD_BEEF);
    check_eq("t1.stall_hold", 32'(stall), 32'd1);
    tick();
    #1;
    check_eq("t1.stall_clr", 32'(stall), 32'd0);
    check_port("t1.after", 1'b0, 5'd0, 32'h0);
    dec_rs1 = '0;

    // Refill under three back-to-back pipeline writes to x7.
    tick();
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h70;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
    #1;
    check_port("t2.c1", 1'b1, 5'd7, 32'h70);
    check_eq("t2.ready", 32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0; wb_data = 32'h71;
    #1 check_port("t2.c2", 1'b1, 5'd7, 32'h71);
    check_eq("t2.ready2", 32'(mem_ready), 32'd1);
    tick();
    wb_data = 32'h72;
    #1 check_port("t2.c3", 1'b1, 5'd7, 32'h72);
    tick();
    wb_we = 1'b0;
    #1 check_port("t2.ref", 1'b1, 5'd6, 32'h66);
    tick();
    #1 check_port("t2.empty", 1'b0, 5'd0, 32'h0);

    // Fill the FIFO under continuous pipeline writes to x8.
    wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'h80;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA;
    #1 check_eq("t3.rdy1", 32'(mem_ready), 32'd1);
    tick();
    mem_rd = 5'd11; mem_data = 32'hB;
    #1 check_eq("t3.rdy2", 32'(mem_ready), 32'd1);
    tick();
    mem_rd = 5'd12; mem_data = 32'hC;
    #1 check_eq("t3.full", 32'(mem_ready), 32'd0);
    check_port("t3.wb", 1'b1, 5'd8, 32'h80);
    tick();
    #1 check_eq("t3.full2", 32'(mem_ready), 32'd0);
    tick();
    wb_we = 1'b0;
    #1;
    check_eq("t3.pushpop", 32'(mem_ready), 32'd1);
    check_port("t3.h10", 1'b1, 5'd10, 32'hA);
    tick();
    mem_valid = 1'b0;
    #1 check_port("t3.h11", 1'b1, 5'd11, 32'hB);
    tick();
    #1 check_port("t3.h12", 1'b1, 5'd12, 32'hC);
    tick();
    #1 check_port("t3.drained", 1'b0, 5'd0, 32'h0);

    // x0 miss and x0 refill never write and never stall.
    miss_issue = 1'b1; miss_rd = 5'd0;
    tick();
    miss_issue = 1'b0;
    #1 check_eq("t4.stall", 32'(stall), 32'd0);
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h123;
    #1 check_port("t4.acc", 1'b0, 5'd0, 32'h0);
    tick();
    mem_valid = 1'b0;
    #1 check_port("t4.pop", 1'b0, 5'd0, 32'h0);
    tick();
    #1 check_port("t4.after", 1'b0, 5'd0, 32'h0);
    check_eq("t4.stall2", 32'(stall), 32'd0);

    // Re-miss on x9 in the cycle its refill commits: busy stays set.
    miss_issue = 1'b1; miss_rd = 5'd9; dec_rs1 = 5'd9;
    tick();
    miss_issue = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    tick();
    mem_valid = 1'b0;
    miss_issue = 1'b1; miss_rd = 5'd9;
    #1;
    check_port("t5.commit", 1'b1, 5'd9, 32'h99);
    check_eq("t5.stall_c", 32'(stall), 32'd1);
    tick();
    miss_issue = 1'b0;
    #1 check_eq("t5.setwins", 32'(stall), 32'd1);
    check_port("t5.idle", 1'b0, 5'd0, 32'h0);

    // Two queued refills plus busy x9, then asynchronous reset mid-cycle.
    wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'h88;
    mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'hD;
    tick();
    mem_rd = 5'd14; mem_data = 32'hE;
    tick();
    mem_valid = 1'b0;
    #1;
    check_eq("t6.full", 32'(mem_ready), 32'd0);
    check_eq("t6.stall", 32'(stall), 32'd1);
    #2 RST = 1'b0;
    #1;
    check_port("t6.rst", 1'b0, 5'd0, 32'h0);
    check_eq("t6.rst_stall", 32'(stall), 32'd0);
    check_eq("t6.rst_ready", 32'(mem_ready), 32'd0);
    tick();
    RST = 1'b1; wb_we = 1'b0;
    #1;
    check_port("t6.rel", 1'b0, 5'd0, 32'h0);
    check_eq("t6.rel_ready", 32'(mem_ready), 32'd1);
    check_eq("t6.rel_stall", 32'(stall), 32'd0);
    tick();
    #1 check_port("t6.nostale", 1'b0, 5'd0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and load scoreboard for the 32x32 register file in the cached RISC-V core. It shares the register file's single write port (WE3/A3/WD3) between the in-order pipeline writeback stage and late load data returned by the cache miss path. It buffers refill writes in a small FIFO and tracks destination registers with outstanding misses. It also produces the decode-stage stall for RAW and WAW hazards on those registers.

## Interface
- DEPTH, 2, refill FIFO entries (power of two, ≥2)
- XLEN, 32, data width
- clk  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous active-low reset
- wb_we  in  1  pipeline writeback request
- wb_rd  in  5  pipeline writeback destination
- wb_data  in  XLEN  pipeline writeback data
- miss_issue  in  1  load missed in cache; its destination becomes pending
- miss_rd  in  5  destination of the missing load
- mem_valid  in  1  refill load data valid
- mem_rd  in  5  refill destination
- mem_data  in  XLEN  refill data
- mem_ready  out  1  refill accepted this cycle when high together with mem_valid
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode-stage operand and destination indices
- stall  out  1  decode must hold
- WE3  out  1  register file write enable
- A3  out  5  register file write address
- WD3  out  XLEN  register file write data

## Operation
- Write-port priority: the pipeline writeback is always granted. The refill path writes only in cycles with no effective pipeline write.
- A pipeline write is effective when wb_we=1 and wb_rd≠0. Writes to x0 are suppressed (WE3=0) and free the port.
- Refill FIFO:
  - An entry is pushed when mem_valid and mem_ready are both high.
  - The head is popped when it is granted the port.
  - An entry with rd=0 is popped without asserting WE3.
- mem_ready = !full, or full with a pop occurring this cycle.
- Scoreboard: 32-bit busy vector.
  - Bit miss_rd is set on miss_issue when miss_rd≠0.
  - Bit A3 is cleared when a refill write is granted.
  - If a set and a clear hit the same register in one cycle, the set wins.
- stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd], with bit 0 forced to 0. Because of this stall, the pipeline never writes a busy register, so FIFO entries and pipeline writes never target the same register in flight.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. full when pointers differ only in the MSB; empty when they are equal.
- Simultaneous push and pop when full: both occur, and occupancy is unchanged.

## Timing
- WE3/A3/WD3 are combinational from the pipeline inputs or the FIFO head. The register file samples them at the same rising edge.
- Refill latency, macro off: mem_valid accepted at edge N. Earliest WE3 is in cycle N+1, written at edge N+1 into the register file array.
- stall is combinational from busy.
  - busy is set one edge after miss_issue.
  - busy is cleared at the edge at which the refill write commits. stall drops in the following cycle.
- Reset (RST low, asynchronous, any time, including mid-refill):
  - FIFO emptied, busy=0.
  - Outputs forced: WE3=0, A3=0, WD3=0, stall=0, mem_ready=0.
  - In-flight refills are discarded; the cache controller is reset by the same RST.
- mem_ready returns high in the first cycle after RST deasserts.

## Configuration
- RF_WB_BYPASS_EN defined: a refill may bypass the FIFO. This happens when mem_valid=1, the FIFO is empty and there is no effective pipeline write. In that case mem_rd/mem_data drive A3/WD3 in the same cycle, the write commits at that edge, and nothing is pushed. Refill latency is 0 cycles.
- RF_WB_BYPASS_EN undefined: every refill passes through the FIFO, giving a minimum 1-cycle latency.

## Structure
- Shared package holds:
  - the refill entry typedef {rd[4:0], data[XLEN-1:0]}
  - REG_X0 = 5'd0
  - the default DEPTH
- One sub-module, rf_wb_fifo (synchronous FIFO with full/empty flags, asynchronous active-low reset), instantiated once.
- Scoreboard, grant mux and stall logic stay in rf_wb_arbiter.

## Test plan
- miss_issue rd=5, then refill rd=5 data=0xDEADBEEF with the pipeline idle:
  - macro off: WE3=1, A3=5, WD3=0xDEADBEEF one cycle after acceptance.
  - busy[5] clears at that edge.
  - stall with dec_rs1=5 holds until that edge.
- Refill arrives while wb_we=1, rd=7 for 3 consecutive cycles:
  - pipeline writes rd=7 each cycle.
  - refill is written in the first idle cycle.
  - mem_ready stays 1 while DEPTH=2 is not exceeded.
- Fill the FIFO (3 refills under continuous pipeline writes):
  - mem_ready=0 after 2 entries.
  - the third refill is accepted in the cycle the pipeline goes idle (pop and push together).
- miss_issue rd=0 and refill rd=0 → busy unchanged, WE3 never asserted, stall=0 for dec_rs1=0.
- miss_issue rd=9 in the same cycle as a refill write commits to rd=9 → busy[9]=1 afterwards.
- Assert RST with 2 FIFO entries and busy≠0 → all outputs 0 immediately. After release: FIFO empty, busy=0, no stale write.
